ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the mips_16 five-stage pipeline. Sits between the ID/EX operand bundle and the MEM stage.
- Resolves RAW hazards by forwarding from the MEM and WB stages, then selects the immediate or register operand.
- Drives the combinational alu (ports a, b, cmd, r), registers the result and control into the EX/MEM pipeline register, and keeps a saturating count of executed operations.

Parameters:
- DATA_W, 16, datapath width (fixed at 16; provided for readability only).
- REG_AW, 3, register address width (8 registers; r0 reads zero).
- CNT_W, 16, width of the executed-op counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- stall  in  1  hold EX/MEM register contents.
- flush  in  1  load bubble into EX/MEM register.
- id_valid  in  1  ID/EX bundle holds a real instruction.
- id_alu_cmd  in  3  ALU command (ALU_* codes).
- id_rs_addr, id_rt_addr  in  3 each  source register addresses.
- id_rs_data, id_rt_data  in  16 each  register file read data.
- id_imm  in  16  sign-extended immediate.
- id_use_imm  in  1  operand b = id_imm instead of forwarded rt.
- id_wb_en, id_wb_addr  in  1, 3  write-back enable and destination.
- id_mem_wr, id_mem_rd  in  1 each  store and load flags.
- mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1, 3, 16  MEM-stage producer.
- wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1, 3, 16  WB-stage producer.
- ex_valid  out  1  EX/MEM holds a real instruction.
- ex_alu_result  out  16  registered ALU result.
- ex_store_data  out  16  registered forwarded rt value, used by stores.
- ex_wb_en, ex_wb_addr  out  1, 3  registered write-back control.
- ex_mem_wr, ex_mem_rd  out  1 each  registered memory control.
- ex_op_count  out  CNT_W  executed-op counter.

Behaviour:
- Reset (rst=0 at a clk edge): every output is 0. Reset has priority over flush and stall.
- Forwarding is combinational and applied per source (rs, rt), in this priority order:
  - Address 0: value is 0. Forwarding is never applied.
  - MEM hit (mem_fwd_en=1 and mem_fwd_addr==addr): mem_fwd_data.
  - WB hit (wb_fwd_en=1 and wb_fwd_addr==addr): wb_fwd_data.
  - Otherwise: id_*_data.
- ALU operands: a = forwarded rs. b = id_imm if id_use_imm=1, else forwarded rt.
- ex_store_data always takes forwarded rt, regardless of id_use_imm.
- ALU arithmetic:
  - Add and sub are 16-bit with wrap-around and no carry or overflow flag.
  - Shift amount is b[3:0].
  - SR is arithmetic (sign-fill); SRU is logical.
  - ALU_NC result is don't-care and is stored as 0.
- Per-clock priority is rst, then flush, then stall, then load.
  - flush=1: ex_valid, ex_wb_en, ex_mem_wr and ex_mem_rd go to 0. Data outputs go to 0. Counter unchanged. Flush wins over a simultaneous stall.
  - stall=1 (no flush): all outputs hold. Counter holds.
  - Load: all outputs take the new values.
    - When id_valid=0, the control bits and ex_valid are forced to 0 (bubble).
- Latency: one clk from the ID bundle to the ex_* outputs. No combinational path from inputs to outputs.
- ex_op_count increments by 1 on each load with id_valid=1 and id_alu_cmd != ALU_NC.
  - It saturates at all-ones with no wrap.
  - It clears only on reset.
- Reset asserted mid-stall or mid-flush: outputs are 0 on the next edge. Stall is ignored that cycle.

Test Plan:
- Reset: drive rst=0 for 2 clk with random inputs -> all outputs 0. Release -> outputs still 0 until the first load.
- Plain ADD: rs=1 (0x1234), rt=2 (0x0F0F), id_use_imm=0, no forwarding -> next clk ex_alu_result=0x2143, ex_valid=1, ex_op_count=1.
- Forward priority:
  - rs=3 with id_rs_data=0x0001, mem_fwd (addr 3, 0x00AA) and wb_fwd (addr 3, 0x00BB), imm=0x0001, use_imm=1, ADD -> result=0x00AB.
  - Drop mem_fwd_en -> result=0x00BC.
  - Repeat with rs=0 -> result=0x0001.
- Shift and imm: a=0xF0F0, use_imm=1, imm=0x0007, SR -> 0xFFE1. Same operands with SRU -> 0x01E1.
- Stall/flush:
  - Load SUB 0x0005-0x0007 -> 0xFFFE.
  - Assert stall for 3 clk while inputs change -> outputs hold 0xFFFE.
  - Assert stall and flush together -> ex_valid=0, ex_wb_en=0, result=0, counter unchanged.
- Counter:
  - Preload via 0xFFFE valid ops (or force) -> 0xFFFF after one more; a further op keeps 0xFFFF.
  - ALU_NC ops and id_valid=0 loads do not count.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register, the forwarding sources and the EX/MEM register.
// The master modport drives the operand bundle and forwarding inputs; the slave modport is the EX stage.
interface ex_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [2:0]        id_alu_cmd;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_wb_en;
  logic [REG_AW-1:0] id_wb_addr;
  logic              id_mem_wr;
  logic              id_mem_rd;
  logic              mem_fwd_en;
  logic [REG_AW-1:0] mem_fwd_addr;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              wb_fwd_en;
  logic [REG_AW-1:0] wb_fwd_addr;
  logic [DATA_W-1:0] wb_fwd_data;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_wb_en;
  logic [REG_AW-1:0] ex_wb_addr;
  logic              ex_mem_wr;
  logic              ex_mem_rd;
  logic [CNT_W-1:0]  ex_op_count;

  modport master (
    output stall, flush, id_valid, id_alu_cmd, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_wb_en, id_wb_addr, id_mem_wr, id_mem_rd,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    input  ex_valid, ex_alu_result, ex_store_data, ex_wb_en, ex_wb_addr, ex_mem_wr, ex_mem_rd,
           ex_op_count
  );

  modport slave (
    input  stall, flush, id_valid, id_alu_cmd, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_wb_en, id_wb_addr, id_mem_wr, id_mem_rd,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    output ex_valid, ex_alu_result, ex_store_data, ex_wb_en, ex_wb_addr, ex_mem_wr, ex_mem_rd,
           ex_op_count
  );
endinterface

// File: rtl/ex_stage.sv
// mips_16 execute stage: MEM/WB forwarding, operand select, ALU, EX/MEM register and a
// saturating executed-op counter.
module ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave io_bus
);

  localparam logic [2:0] ALU_NC  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SL  = 3'd5;
  localparam logic [2:0] ALU_SR  = 3'd6;
  localparam logic [2:0] ALU_SRU = 3'd7;

  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_r;
  logic              w_count_op;

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_store_data;
  logic              r_wb_en;
  logic [REG_AW-1:0] r_wb_addr;
  logic              r_mem_wr;
  logic              r_mem_rd;
  logic [CNT_W-1:0]  r_op_count;

  // r0 is hardwired zero, so a producer targeting r0 must never be forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              mem_en,
    input logic [REG_AW-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    if (addr == '0)                        return '0;
    else if (mem_en && (mem_addr == addr)) return mem_data;
    else if (wb_en && (wb_addr == addr))   return wb_data;
    else                                   return rf_data;
  endfunction

  always_comb begin
    w_rs_fwd = fwd_sel(io_bus.id_rs_addr, io_bus.id_rs_data, io_bus.mem_fwd_en,
                       io_bus.mem_fwd_addr, io_bus.mem_fwd_data, io_bus.wb_fwd_en,
                       io_bus.wb_fwd_addr, io_bus.wb_fwd_data);
    w_rt_fwd = fwd_sel(io_bus.id_rt_addr, io_bus.id_rt_data, io_bus.mem_fwd_en,
                       io_bus.mem_fwd_addr, io_bus.mem_fwd_data, io_bus.wb_fwd_en,
                       io_bus.wb_fwd_addr, io_bus.wb_fwd_data);
    w_alu_a  = w_rs_fwd;
    w_alu_b  = io_bus.id_use_imm ? io_bus.id_imm : w_rt_fwd;
  end

  always_comb begin
    w_alu_r = '0;
    case (io_bus.id_alu_cmd)
      ALU_ADD: w_alu_r = w_alu_a + w_alu_b;
      ALU_SUB: w_alu_r = w_alu_a - w_alu_b;
      ALU_AND: w_alu_r = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_r = w_alu_a | w_alu_b;
      ALU_SL:  w_alu_r = w_alu_a << w_alu_b[3:0];
      ALU_SR:  w_alu_r = $unsigned($signed(w_alu_a) >>> w_alu_b[3:0]);
      ALU_SRU: w_alu_r = w_alu_a >> w_alu_b[3:0];
      default: w_alu_r = '0;
    endcase
  end

  assign w_count_op = io_bus.id_valid && (io_bus.id_alu_cmd != ALU_NC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_mem_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_op_count   <= '0;
    end else if (io_bus.flush) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_mem_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
    end else if (!io_bus.stall) begin
      r_valid      <= io_bus.id_valid;
      r_alu_result <= w_alu_r;
      r_store_data <= w_rt_fwd;
      r_wb_en      <= io_bus.id_valid & io_bus.id_wb_en;
      r_wb_addr    <= io_bus.id_wb_addr;
      r_mem_wr     <= io_bus.id_valid & io_bus.id_mem_wr;
      r_mem_rd     <= io_bus.id_valid & io_bus.id_mem_rd;
      if (w_count_op && (r_op_count != '1)) r_op_count <= r_op_count + 1'b1;
    end
  end

  assign io_bus.ex_valid      = r_valid;
  assign io_bus.ex_alu_result = r_alu_result;
  assign io_bus.ex_store_data = r_store_data;
  assign io_bus.ex_wb_en      = r_wb_en;
  assign io_bus.ex_wb_addr    = r_wb_addr;
  assign io_bus.ex_mem_wr     = r_mem_wr;
  assign io_bus.ex_mem_rd     = r_mem_rd;
  assign io_bus.ex_op_count   = r_op_count;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, forwarding priority, shifts, stall/flush and counter
// saturation, each checked against hand-computed values.
module tb_ex_stage;

  localparam logic [2:0] ALU_NC  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SL  = 3'd5;
  localparam logic [2:0] ALU_SR  = 3'd6;
  localparam logic [2:0] ALU_SRU = 3'd7;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_stage_if bus ();

  ex_stage dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic valid, input logic [2:0] cmd,
                    input logic [2:0] rs, input logic [15:0] rsd,
                    input logic [2:0] rt, input logic [15:0] rtd,
                    input logic [15:0] imm, input logic use_imm);
    bus.id_valid   = valid;
    bus.id_alu_cmd = cmd;
    bus.id_rs_addr = rs;
    bus.id_rs_data = rsd;
    bus.id_rt_addr = rt;
    bus.id_rt_data = rtd;
    bus.id_imm     = imm;
    bus.id_use_imm = use_imm;
  endtask

  function automatic logic [63:0] all_out();
    return {bus.ex_valid, bus.ex_alu_result, bus.ex_store_data, bus.ex_wb_en, bus.ex_wb_addr,
            bus.ex_mem_wr, bus.ex_mem_rd, bus.ex_op_count};
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // Reset with random inputs.
    rst              = 1'b0;
    bus.stall        = 1'($urandom);
    bus.flush        = 1'($urandom);
    op(1'b1, 3'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
       16'($urandom), 1'($urandom));
    bus.id_wb_en     = 1'b1;
    bus.id_wb_addr   = 3'($urandom);
    bus.id_mem_wr    = 1'b1;
    bus.id_mem_rd    = 1'b1;
    bus.mem_fwd_en   = 1'($urandom);
    bus.mem_fwd_addr = 3'($urandom);
    bus.mem_fwd_data = 16'($urandom);
    bus.wb_fwd_en    = 1'($urandom);
    bus.wb_fwd_addr  = 3'($urandom);
    bus.wb_fwd_data  = 16'($urandom);
    step();
    chk("reset_cycle1", all_out(), 64'd0);
    step();
    chk("reset_cycle2", all_out(), 64'd0);

    // Release: bubble loads keep everything at zero.
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    op(1'b0, ALU_NC, 3'd0, 16'd0, 3'd0, 16'd0, 16'd0, 1'b0);
    bus.id_wb_en   = 1'b0;
    bus.id_wb_addr = 3'd0;
    bus.id_mem_wr  = 1'b0;
    bus.id_mem_rd  = 1'b0;
    bus.mem_fwd_en = 1'b0;
    bus.wb_fwd_en  = 1'b0;
    rst = 1'b1;
    step();
    chk("post_reset_idle", all_out(), 64'd0);

    // Plain ADD.
    op(1'b1, ALU_ADD, 3'd1, 16'h1234, 3'd2, 16'h0F0F, 16'h0000, 1'b0);
    bus.id_wb_en   = 1'b1;
    bus.id_wb_addr = 3'd4;
    step();
    chk("add_result", bus.ex_alu_result, 16'h2143);
    chk("add_valid", bus.ex_valid, 1'b1);
    chk("add_count", bus.ex_op_count, 16'd1);
    chk("add_store", bus.ex_store_data, 16'h0F0F);
    chk("add_wb", {bus.ex_wb_en, bus.ex_wb_addr}, {1'b1, 3'd4});

    // Forwarding priority: MEM over WB over register file.
    op(1'b1, ALU_ADD, 3'd3, 16'h0001, 3'd3, 16'h0002, 16'h0001, 1'b1);
    bus.mem_fwd_en = 1'b1; bus.mem_fwd_addr = 3'd3; bus.mem_fwd_data = 16'h00AA;
    bus.wb_fwd_en  = 1'b1; bus.wb_fwd_addr  = 3'd3; bus.wb_fwd_data  = 16'h00BB;
    step();
    chk("fwd_mem", bus.ex_alu_result, 16'h00AB);
    chk("fwd_mem_store", bus.ex_store_data, 16'h00AA);
    bus.mem_fwd_en = 1'b0;
    step();
    chk("fwd_wb", bus.ex_alu_result, 16'h00BC);
    chk("fwd_wb_store", bus.ex_store_data, 16'h00BB);
    bus.id_rs_addr = 3'd0;
    bus.mem_fwd_en = 1'b1; bus.mem_fwd_addr = 3'd0;
    bus.wb_fwd_addr = 3'd0;
    step();
    chk("fwd_r0", bus.ex_alu_result, 16'h0001);
    chk("fwd_r0_count", bus.ex_op_count, 16'd4);
    bus.mem_fwd_en = 1'b0;
    bus.wb_fwd_en  = 1'b0;

    // Shifts and OR.
    op(1'b1, ALU_SR, 3'd5, 16'hF0F0, 3'd6, 16'h0000, 16'h0007, 1'b1);
    step();
    chk("sr", bus.ex_alu_result, 16'hFFE1);
    bus.id_alu_cmd = ALU_SRU;
    step();
    chk("sru", bus.ex_alu_result, 16'h01E1);
    op(1'b1, ALU_SL, 3'd5, 16'h0003, 3'd6, 16'h0000, 16'h0014, 1'b1);
    step();
    chk("sl_low_nibble", bus.ex_alu_result, 16'h0030);
    op(1'b1, ALU_OR, 3'd5, 16'h0F00, 3'd6, 16'h00F0, 16'hFFFF, 1'b0);
    step();
    chk("or_reg_b", bus.ex_alu_result, 16'h0FF0);
    chk("or_count", bus.ex_op_count, 16'd8);

    // Stall then flush.
    op(1'b1, ALU_SUB, 3'd1, 16'h0005, 3'd2, 16'h0007, 16'h0000, 1'b0);
    bus.id_mem_wr = 1'b1;
    step();
    chk("sub_wrap", bus.ex_alu_result, 16'hFFFE);
    chk("sub_mem_wr", bus.ex_mem_wr, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(1'b1, ALU_ADD, 3'd1, 16'(i + 16'h0100), 3'd2, 16'h0033, 16'h0000, 1'b0);
      step();
      chk("stall_hold_result", bus.ex_alu_result, 16'hFFFE);
      chk("stall_hold_count", bus.ex_op_count, 16'd9);
    end
    bus.flush = 1'b1;
    step();
    chk("flush_ctrl", {bus.ex_valid, bus.ex_wb_en, bus.ex_mem_wr, bus.ex_mem_rd}, 4'd0);
    chk("flush_data", {bus.ex_alu_result, bus.ex_store_data}, 32'd0);
    chk("flush_count", bus.ex_op_count, 16'd9);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.id_mem_wr = 1'b0;

    // Non-counting loads.
    op(1'b0, ALU_ADD, 3'd1, 16'h0010, 3'd2, 16'h0020, 16'h0000, 1'b0);
    step();
    chk("bubble_ctrl", {bus.ex_valid, bus.ex_wb_en}, 2'd0);
    chk("bubble_count", bus.ex_op_count, 16'd9);
    op(1'b1, ALU_NC, 3'd1, 16'h0010, 3'd2, 16'h0020, 16'h0000, 1'b0);
    step();
    chk("nc_result", bus.ex_alu_result, 16'h0000);
    chk("nc_valid", bus.ex_valid, 1'b1);
    chk("nc_count", bus.ex_op_count, 16'd9);

    // Counter saturation.
    op(1'b1, ALU_ADD, 3'd1, 16'h0001, 3'd2, 16'h0001, 16'h0000, 1'b0);
    for (int i = 0; i < 16'hFFFE - 9; i++) step();
    chk("count_preload", bus.ex_op_count, 16'hFFFE);
    step();
    chk("count_max", bus.ex_op_count, 16'hFFFF);
    op(1'b1, ALU_ADD, 3'd1, 16'hFFFF, 3'd2, 16'h0002, 16'h0000, 1'b0);
    step();
    chk("count_saturate", bus.ex_op_count, 16'hFFFF);
    chk("add_wrap", bus.ex_alu_result, 16'h0001);

    // Reset during stall.
    bus.stall = 1'b1;
    rst = 1'b0;
    step();
    chk("reset_mid_stall", all_out(), 64'd0);
    rst = 1'b1;
    bus.stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
